// File: rtl/vita49_trig_gate.sv
// rtl/vita49_trig_gate.sv - timed trigger and sample gate driven by the VITA49 {TSI,TSF} timestamp
module vita49_trig_gate #(
  parameter int TSF_WIDTH = 64,
  parameter int TSI_WIDTH = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 samp_clk,
  input  logic                 ARESETN,
  input  logic [31:0]          ctrl,
  input  logic [TSI_WIDTH-1:0] trig_tsi,
  input  logic [TSF_WIDTH-1:0] trig_tsf,
  input  logic [CNT_WIDTH-1:0] run_len,
  input  logic [TSI_WIDTH-1:0] tsi,
  input  logic [TSF_WIDTH-1:0] tsf,
  output logic                 trig_out,
  output logic                 gate,
  output logic [TSI_WIDTH-1:0] fire_tsi,
  output logic [TSF_WIDTH-1:0] fire_tsf,
  output logic [31:0]          status
);

  localparam int TW = TSI_WIDTH + TSF_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    ACTIVE = 3'd2,
    DONE   = 3'd3,
    LATE   = 3'd4
  } state_t;

  state_t               state, state_d;
  logic                 arm, abort, immediate;
  logic                 arm_q, arm_rise;
  logic [TW-1:0]        time_q, target;
  logic [CNT_WIDTH-1:0] run_q, cnt, fire_cnt;
  logic                 late_ok_q, late_sticky;
  logic                 match, past, fire, go_late, accept_arm;
  logic                 ctrl_unused;

  assign arm         = ctrl[0];
  assign abort       = ctrl[1];
  assign immediate   = ctrl[2];
  assign ctrl_unused = ^ctrl[31:4];
  assign arm_rise    = arm & ~arm_q;
  assign match       = (time_q == target);
  assign past        = (time_q > target);
  assign accept_arm  = (state == IDLE) && arm_rise && !abort;
  // An immediate fire happens on the arming edge, before run_q has been loaded.
  assign fire_cnt    = (state == IDLE) ? run_len : run_q;

  always_ff @(posedge samp_clk or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    fire    = 1'b0;
    go_late = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: if (arm_rise) begin
          if (immediate) begin
            state_d = ACTIVE;
            fire    = 1'b1;
          end else begin
            state_d = ARMED;
          end
        end
        ARMED: if (match || (past && late_ok_q)) begin
          state_d = ACTIVE;
          fire    = 1'b1;
        end else if (past) begin
          state_d = LATE;
          go_late = 1'b1;
        end
        ACTIVE: if ((run_q != '0) && (cnt == CNT_ONE)) state_d = DONE;
        DONE, LATE: if (!arm) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge samp_clk or negedge ARESETN) begin
    if (!ARESETN) begin
      time_q      <= '0;
      arm_q       <= 1'b0;
      target      <= '0;
      run_q       <= '0;
      late_ok_q   <= 1'b0;
      late_sticky <= 1'b0;
      cnt         <= '0;
      trig_out    <= 1'b0;
      fire_tsi    <= '0;
      fire_tsf    <= '0;
    end else begin
      time_q   <= {tsi, tsf};
      arm_q    <= arm;
      trig_out <= fire;
      if (accept_arm) begin
        target      <= {trig_tsi, trig_tsf};
        run_q       <= run_len;
        late_ok_q   <= ctrl[3];
        late_sticky <= 1'b0;
      end else if (go_late) begin
        late_sticky <= 1'b1;
      end
      if (abort) begin
        cnt <= '0;
      end else if (fire) begin
        cnt      <= fire_cnt;
        fire_tsi <= time_q[TW-1 -: TSI_WIDTH];
        fire_tsf <= time_q[TSF_WIDTH-1:0];
      end else if ((state == ACTIVE) && (run_q != '0) && (cnt != CNT_ONE)) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  always_comb begin
    gate   = (state == ACTIVE);
    status = {26'd0, (state == ARMED), gate, late_sticky, state};
  end

endmodule

// File: tb/tb_vita49_trig_gate.sv
// tb/tb_vita49_trig_gate.sv - scoreboard bench for vita49_trig_gate
module tb_vita49_trig_gate;

  logic         samp_clk;
  logic         ARESETN;
  logic [31:0]  ctrl;
  logic [31:0]  trig_tsi;
  logic [63:0]  trig_tsf;
  logic [31:0]  run_len;
  logic [31:0]  tsi;
  logic [63:0]  tsf;
  logic         trig_out;
  logic         gate;
  logic [31:0]  fire_tsi;
  logic [63:0]  fire_tsf;
  logic [31:0]  status;

  vita49_trig_gate dut (
    .samp_clk (samp_clk),
    .ARESETN  (ARESETN),
    .ctrl     (ctrl),
    .trig_tsi (trig_tsi),
    .trig_tsf (trig_tsf),
    .run_len  (run_len),
    .tsi      (tsi),
    .tsf      (tsf),
    .trig_out (trig_out),
    .gate     (gate),
    .fire_tsi (fire_tsi),
    .fire_tsf (fire_tsf),
    .status   (status)
  );

  typedef struct {
    logic [31:0] tsi;
    logic [63:0] tsf;
    int          len;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  bit   counting = 0;
  int   gcount = 0;
  int   cur_len = 0;

  initial begin
    samp_clk = 1'b0;
    forever #5 samp_clk = ~samp_clk;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge samp_clk);
    #1;
  endtask

  task automatic expect_fire(input logic [31:0] s, input logic [63:0] f, input int len);
    exp_t e;
    e.tsi = s;
    e.tsf = f;
    e.len = len;
    exp_q.push_back(e);
  endtask

  // Each trigger pops one expected fire and then measures the gate width.
  always @(negedge samp_clk) begin
    if (!ARESETN) begin
      counting = 0;
    end else begin
      if (trig_out) begin
        if (exp_q.size() == 0) begin
          check("unexp_trig", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("fire_tsi", fire_tsi, mon_e.tsi);
          check("fire_tsf", fire_tsf, mon_e.tsf);
          check("trig_gate", gate, 1);
          cur_len  = mon_e.len;
          counting = 1;
          gcount   = 0;
        end
      end
      if (counting) begin
        if (gate) begin
          gcount++;
        end else begin
          counting = 0;
          if (cur_len == 0) check("gate_cont", gcount >= 1000, 1);
          else              check("gate_len", gcount, cur_len);
        end
      end
    end
  end

  initial begin
    ARESETN  = 1'b0;
    ctrl     = '0;
    trig_tsi = '0;
    trig_tsf = '0;
    run_len  = '0;
    tsi      = '0;
    tsf      = '0;
    tick(3);
    check("rst_status", status, 0);
    check("rst_gate", gate, 0);
    check("rst_trig", trig_out, 0);
    check("rst_fire_tsf", fire_tsf, 0);

    // nominal timed fire
    ARESETN  = 1'b1;
    trig_tsi = 5;
    trig_tsf = 100;
    run_len  = 4;
    tsi      = 5;
    tsf      = 90;
    tick(2);
    ctrl = 32'h1;
    expect_fire(5, 100, 4);
    tick(1);
    check("t1_armed_state", status[2:0], 1);
    check("t1_armed_bit", status[5], 1);
    for (int k = 91; k <= 120; k++) begin
      tsf = k;
      tick(1);
      check("t1_trig_timing", trig_out, (k == 101));
    end
    check("t1_done", status[2:0], 3);
    check("t1_gate_off", gate, 0);
    ctrl = 32'h0;
    tsi  = 3;
    tsf  = 0;
    tick(1);
    check("t1_idle", status[2:0], 0);

    // late target, then late_ok
    trig_tsi = 2;
    trig_tsf = 0;
    ctrl = 32'h1;
    tick(1);
    check("t2_armed", status[2:0], 1);
    tick(1);
    check("t2_late", status[2:0], 4);
    check("t2_sticky", status[3], 1);
    tick(3);
    check("t2_no_gate", gate, 0);
    ctrl = 32'h0;
    tick(1);
    check("t2_idle", status[2:0], 0);
    check("t2_sticky_hold", status[3], 1);
    ctrl = 32'h9;
    expect_fire(3, 0, 4);
    tick(1);
    check("t2_sticky_clr", status[3], 0);
    tick(1);
    check("t2_lateok_trig", trig_out, 1);
    tick(5);
    check("t2_done", status[2:0], 3);
    ctrl = 32'h0;
    tick(1);

    // immediate fire, single cycle gate
    run_len = 1;
    ctrl = 32'h5;
    expect_fire(3, 0, 1);
    tick(1);
    check("t3_trig", trig_out, 1);
    check("t3_gate", gate, 1);
    check("t3_active", status[2:0], 2);
    tick(1);
    check("t3_gate_off", gate, 0);
    check("t3_done", status[2:0], 3);
    ctrl = 32'h0;
    tick(1);

    // continuous gate ended by abort
    trig_tsi = 7;
    trig_tsf = 50;
    run_len  = 0;
    tsi      = 7;
    tsf      = 40;
    ctrl = 32'h1;
    expect_fire(7, 50, 0);
    tick(1);
    tsf = 50;
    tick(1);
    check("t4_pre_trig", trig_out, 0);
    tick(1);
    check("t4_trig", trig_out, 1);
    tick(1005);
    check("t4_gate_on", gate, 1);
    check("t4_active", status[2:0], 2);
    ctrl = 32'h3;
    tick(1);
    check("t4_abort_gate", gate, 0);
    check("t4_abort_idle", status[2:0], 0);
    ctrl = 32'h0;
    tick(1);

    // abort while armed, arm held high does not re-arm
    trig_tsi = 8;
    trig_tsf = 0;
    run_len  = 3;
    tsi      = 7;
    tsf      = 0;
    ctrl = 32'h1;
    tick(1);
    check("t5_armed", status[2:0], 1);
    ctrl = 32'h3;
    tick(1);
    check("t5_abort_idle", status[2:0], 0);
    ctrl = 32'h1;
    tsi  = 9;
    tick(5);
    check("t5_no_rearm", status[2:0], 0);
    check("t5_no_trig", trig_out, 0);
    ctrl = 32'h0;
    tick(1);
    ctrl = 32'h1;
    tick(1);
    check("t5_rearm", status[2:0], 1);
    tick(1);
    check("t5_late", status[2:0], 4);
    ctrl = 32'h0;
    tick(1);

    // async reset mid-ACTIVE, then fresh arm
    trig_tsi = 10;
    trig_tsf = 0;
    run_len  = 50;
    tsi      = 10;
    tsf      = 0;
    ctrl = 32'h1;
    expect_fire(10, 0, 50);
    tick(2);
    check("t6_trig", trig_out, 1);
    tick(5);
    check("t6_gate_on", gate, 1);
    #2;
    ARESETN = 1'b0;
    #1;
    check("t6_rst_gate", gate, 0);
    check("t6_rst_trig", trig_out, 0);
    check("t6_rst_status", status, 0);
    ctrl = 32'h0;
    tick(2);
    ARESETN = 1'b1;
    tick(1);
    check("t6_idle", status, 0);
    run_len = 2;
    ctrl = 32'h1;
    expect_fire(10, 0, 2);
    tick(1);
    check("t6_armed", status[2:0], 1);
    tick(1);
    check("t6_refire", trig_out, 1);
    tick(3);
    check("t6_done", status[2:0], 3);
    ctrl = 32'h0;
    tick(3);
    check("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vita49_trig_gate.md
Name: vita49_trig_gate

Overview:
- Timed-event consumer for the VITA49 timestamp pair (TSI integer seconds, TSF sample count) produced by the clock/timestamp logic.
- The processor programs a target timestamp and a run length, then arms the block.
- When the running timestamp reaches the target, the block fires a one-cycle trigger pulse and opens a sample gate for exactly run_len cycles.
- One instance per sample-clock domain. It sits between the timestamp generator and the TX/RX sample datapath enables.

Parameters:
- TSF_WIDTH, 64, width of the fractional timestamp (tsf, trig_tsf, fire_tsf).
- TSI_WIDTH, 32, width of the integer timestamp (tsi, trig_tsi, fire_tsi).
- CNT_WIDTH, 32, width of run_len and the gate down-counter.

Ports:
- samp_clk, in, 1: sample clock, the only clock.
- ARESETN, in, 1: asynchronous active-low reset.
- ctrl, in, 32: processor control; all other bits ignored.
  - [0] arm
  - [1] abort
  - [2] immediate
  - [3] late_ok
- trig_tsi, in, TSI_WIDTH: target integer seconds.
- trig_tsf, in, TSF_WIDTH: target fractional count.
- run_len, in, CNT_WIDTH: gate length in samp_clk cycles; 0 = continuous.
- tsi, in, TSI_WIDTH: running integer timestamp, samp_clk domain.
- tsf, in, TSF_WIDTH: running fractional timestamp, samp_clk domain.
- trig_out, out, 1: one-cycle pulse on fire.
- gate, out, 1: high while ACTIVE.
- fire_tsi, out, TSI_WIDTH: time_q.tsi captured at fire.
- fire_tsf, out, TSF_WIDTH: time_q.tsf captured at fire.
- status, out, 32: bits assigned as follows, all other bits 0.
  - [2:0] state
  - [3] late sticky
  - [4] gate
  - [5] armed

Behaviour:
- Reset (ARESETN=0, asynchronous):
  - state=IDLE.
  - trig_out, gate, fire_tsi, fire_tsf, targets, counter, time_q and arm_q all 0.
  - status=0.
- Every edge:
  - time_q <= {tsi,tsf}.
  - arm_q <= ctrl[0].
  - arm_rise = ctrl[0] & ~arm_q.
- Compare rules:
  - Compare is unsigned over the concatenated {TSI,TSF} value.
  - match = time_q == target; past = time_q > target.
- trig_out is registered and is high for exactly the edge that enters ACTIVE; otherwise 0.
- State encoding: IDLE=0, ARMED=1, ACTIVE=2, DONE=3, LATE=4.
- IDLE:
  - On arm_rise: latch target <= {trig_tsi,trig_tsf}, run_q <= run_len, late_ok_q <= ctrl[3].
  - If ctrl[2]=1, go directly to ACTIVE (immediate fire) on that edge; otherwise go to ARMED.
- ARMED:
  - match -> fire.
  - else past & late_ok_q -> fire.
  - else past -> LATE, set late sticky.
  - else stay in ARMED.
- Fire latency:
  - If tsi/tsf inputs equal the target when sampled at edge m, trig_out and gate are high after edge m+1.
  - fire_tsi/fire_tsf are loaded with time_q at the fire edge and hold until the next fire or reset.
- Fire actions: state <= ACTIVE, gate <= 1, trig_out <= 1, cnt <= run_q.
- ACTIVE:
  - If run_q=0: stay in ACTIVE until abort.
  - Otherwise, on each edge: if cnt==1, gate <= 0 and state <= DONE; else cnt <= cnt-1.
  - Gate is therefore high for exactly run_len cycles.
- DONE / LATE:
  - Hold; gate=0.
  - Return to IDLE on the first edge with ctrl[0]=0.
  - Re-arming requires a new arm_rise.
- Late sticky: cleared on the next arm_rise.
- Abort (ctrl[1]=1):
  - Highest priority in every state.
  - Next edge: state <= IDLE, gate <= 0, trig_out <= 0, cnt <= 0.
  - Abort held high blocks arming.
  - Simultaneous arm_rise and abort -> IDLE.
- Arm level:
  - arm is level-sampled; arm held high does not re-fire after DONE.
  - Deasserting arm while ARMED or ACTIVE does not cancel; use abort.
- Target and run_len changes while ARMED/ACTIVE are ignored; values are latched at arm.
- Time jumps: a jump via set_tsi or reset that skips past the target is handled by the past rule. A backwards jump while ARMED simply keeps waiting.
- status[5] = (state==ARMED).

Test Plan:
- Arm with target TSI=5, TSF=100, run_len=4, late_ok=0; drive tsi=5 and tsf counting 90..120 -> trig_out pulses once after the edge following tsf=100; gate high exactly 4 cycles; fire_tsi=5, fire_tsf=100; state ends DONE (3).
- Arm with target TSI=2, TSF=0 while tsi=3, late_ok=0 -> state LATE (4), status[3]=1, gate never high. Repeat with late_ok=1 -> fires on the first ARMED compare; fire_tsi=3.
- Immediate=1, run_len=1 -> gate high 1 cycle starting after the arming edge; trig_out coincides with gate.
- run_len=0, target reached -> gate stays high 1000+ cycles; abort -> gate 0 after next edge; state IDLE.
- Abort asserted while ARMED, then tsi/tsf pass the target -> no trig_out; arm held high with abort dropped -> no re-arm until arm toggles 0 -> 1.
- Assert ARESETN=0 mid-ACTIVE (gate=1) -> gate, trig_out and status go to 0 immediately, without a clock edge; after release the block is IDLE and a fresh arm works normally.
